// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH.
//             One bit per clock, LSB first, with a registered borrow chain
//             and a start/busy/done handshake. The result and final borrow
//             are held in output registers until the next completion.
//  Ports    : clk    - clock, rising edge
//             rst    - synchronous active-high reset
//             start  - launch request, accepted when busy is low
//             a, b   - minuend / subtrahend, captured on an accepted start
//             busy   - high while bits are being processed
//             done   - one-cycle pulse when diff/borrow have just updated
//             diff   - held result (a - b) mod 2^WIDTH
//             borrow - held final borrow, high when a < b
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter only needs to reach WIDTH-1; RUN is left on that bit.
  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             bw_q,     bw_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Single full-subtractor cell operating on the current LSBs.
  logic ai, bi, d_bit, bw_next;

  always_comb begin
    ai      = a_sh_q[0];
    bi      = b_sh_q[0];
    d_bit   = ai ^ bi ^ bw_q;
    bw_next = (~ai & bi) | (~(ai ^ bi) & bw_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          bw_d     = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Result bits enter at the MSB, so after WIDTH shifts bit 0 has
        // arrived at position 0.
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
        bw_d     = bw_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = {d_bit, res_sh_q[WIDTH-1:1]};
          borrow_d = bw_next;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they come straight
    // out of flops.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor at WIDTH=8 and
//             WIDTH=4 against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow;
  logic [7:0] diff;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer modular subtraction.
  function automatic int ref_diff(input int x, input int y, input int w);
    return (x - y + (1 << w)) % (1 << w);
  endfunction

  function automatic int ref_borrow(input int x, input int y);
    return (x < y) ? 1 : 0;
  endfunction

  // One WIDTH=8 operation. Operands are scrambled after capture; optionally
  // a stray start is poked mid-run, and the previous result is checked held.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit poke,
                        input bit hold, input logic [7:0] held_d, input logic held_b);
    int n = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && n < 20) begin
      if (hold) begin
        check("held_diff", 32'(diff), 32'(held_d));
        check("held_borrow", 32'(borrow), 32'(held_b));
      end
      if (busy) busy_cnt++;
      if (poke && n == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd8);
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    check("busy_at_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(ref_diff(int'(av), int'(bv), 8)));
    check("borrow", 32'(borrow), 32'(ref_borrow(int'(av), int'(bv))));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // WIDTH=8 back-to-back with start held high.
  task automatic b2b8(input int nops);
    logic [7:0] qa[$], qb[$];
    int cyc = 0, last = 0, got = 0, sent = 0, guard = 0;
    for (int i = 0; i < nops; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
    end
    @(negedge clk);
    start = 1'b1; a = qa[0]; b = qb[0]; sent = 1;
    while (got < nops && guard < nops * 9 + 30) begin
      @(negedge clk);
      cyc++; guard++;
      if (done) begin
        check("b2b8_interval", 32'(cyc - last), 32'd9);
        check("b2b8_diff", 32'(diff), 32'(ref_diff(int'(qa[got]), int'(qb[got]), 8)));
        check("b2b8_borrow", 32'(borrow), 32'(ref_borrow(int'(qa[got]), int'(qb[got]))));
        last = cyc; got++;
        if (sent < nops) begin
          a = qa[sent]; b = qb[sent]; sent++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b8_count", 32'(got), 32'(nops));
  endtask

  // WIDTH=4 exhaustive, back-to-back, in a randomly rotated permuted order.
  task automatic b2b4();
    int cyc = 0, last = 0, got = 0, sent = 0, guard = 0;
    int seed = int'($urandom_range(0, 255));
    int ord[256];
    for (int i = 0; i < 256; i++) ord[i] = (i * 167 + seed) % 256;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'(ord[0] >> 4); b4 = 4'(ord[0]); sent = 1;
    while (got < 256 && guard < 256 * 5 + 30) begin
      @(negedge clk);
      cyc++; guard++;
      if (done4) begin
        check("b2b4_interval", 32'(cyc - last), 32'd5);
        check("b2b4_diff", 32'(diff4), 32'(ref_diff(ord[got] >> 4, ord[got] & 15, 4)));
        check("b2b4_borrow", 32'(borrow4), 32'(ref_borrow(ord[got] >> 4, ord[got] & 15)));
        last = cyc; got++;
        if (sent < 256) begin
          a4 = 4'(ord[sent] >> 4); b4 = 4'(ord[sent]); sent++;
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    check("b2b4_count", 32'(got), 32'd256);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_diff4", 32'(diff4), 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);

    // Stray start mid-run is ignored; no extra done afterwards.
    run_op(8'h10, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_extra_done", 32'(dones), 32'd0);
    check("no_extra_busy", 32'(busy), 32'd0);

    // Result 0x0F held during the next operation.
    run_op(8'($urandom), 8'($urandom), 1'b0, 1'b1, 8'h0F, 1'b0);

    b2b8(6);

    // Reset at bit 4 of an operation.
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h2D;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(8'h7E, 8'h81, 1'b0, 1'b1, 8'h00, 1'b0);

    // Random single operations.
    for (int i = 0; i < 12; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
    end

    b2b4();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
